// File: rtl/m_ocp_arbiter.sv
// Round-robin arbiter sharing one OCP bridge memory-access port between
// NUM_REQ requesters. It keeps one access outstanding at a time and enforces a completion timeout.
module m_ocp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_type,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          arb_busy,
  output logic                          br_request,
  output logic                          br_type,
  output logic [ADDR_WIDTH-1:0]         br_address,
  output logic [DATA_WIDTH-1:0]         br_write_data,
  input  logic [DATA_WIDTH-1:0]         br_read_data,
  input  logic                          br_complete,
  input  logic                          br_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  // First pending request at or above rr_ptr, wrapping back to 0.
  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    sel_valid = 1'b0;
    sel_idx   = '0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      idx           <= '0;
      cnt           <= '0;
      grant         <= '0;
      done          <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      arb_busy      <= 1'b0;
      br_request    <= 1'b0;
      br_type       <= 1'b0;
      br_address    <= '0;
      br_write_data <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge register values.
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      br_request <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            idx           <= sel_idx;
            grant         <= NUM_REQ'(1) << sel_idx;
            br_type       <= req_type[sel_idx];
            br_address    <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            br_write_data <= req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            arb_busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!br_busy) begin
            br_request <= 1'b1;
            cnt        <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // A completion wins over a timeout that expires in the same cycle.
          if (br_complete) begin
            if (br_type) rdata <= br_read_data;
            done  <= NUM_REQ'(1) << idx;
            state <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            err   <= 1'b1;
            done  <= NUM_REQ'(1) << idx;
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          rr_ptr   <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_ocp_arbiter.sv
// Self-checking bench for m_ocp_arbiter: directed scenarios plus randomized
// accesses checked against a round-robin reference model.
module tb_m_ocp_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int TO   = 8;
  localparam int OB_W = 2*N + 2*DW + AW + 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_type;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            arb_busy;
  logic            br_request;
  logic            br_type;
  logic [AW-1:0]   br_address;
  logic [DW-1:0]   br_write_data;
  logic [DW-1:0]   br_read_data;
  logic            br_complete;
  logic            br_busy;

  int vectors     = 0;
  int miscompares = 0;

  int            model_ptr;
  logic [DW-1:0] model_rdata;

  m_ocp_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata), .err(err), .arb_busy(arb_busy),
    .br_request(br_request), .br_type(br_type), .br_address(br_address),
    .br_write_data(br_write_data), .br_read_data(br_read_data),
    .br_complete(br_complete), .br_busy(br_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OB_W-1:0] out_bus();
    return {grant, done, rdata, err, arb_busy, br_request, br_type, br_address, br_write_data};
  endfunction

  // Reference rule: first requester at or after the pointer, wrapping modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset_n      = 1'b0;
    req          = '0;
    req_type     = '0;
    req_addr     = '0;
    req_wdata    = '0;
    br_read_data = '0;
    br_complete  = 1'b0;
    br_busy      = 1'b0;
    model_ptr    = 0;
    model_rdata  = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // One complete access: grant, optional busy stall, request pulse, completion or timeout, done.
  task automatic do_access(input string tag, input logic [N-1:0] reqv, input logic [N-1:0] types,
                           input logic [N*AW-1:0] addrs, input logic [N*DW-1:0] wdatas,
                           input logic [DW-1:0] ret, input int busy_cyc, input int lat,
                           input bit timeout, input bit hold, output int gidx);
    int            w;
    int            nw;
    logic [N-1:0]  exp_oh;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          et;
    w      = rr_pick(reqv, model_ptr);
    exp_oh = N'(1) << w;
    ea     = addrs[w*AW +: AW];
    ew     = wdatas[w*DW +: DW];
    et     = types[w];
    req       = reqv;
    req_type  = types;
    req_addr  = addrs;
    req_wdata = wdatas;
    br_busy   = (busy_cyc > 0);
    step();
    gidx = -1;
    for (int i = N - 1; i >= 0; i--) if (grant[i]) gidx = i;
    vectors++;
    if ({grant, br_type, br_address, br_write_data} !== {exp_oh, et, ea, ew}) begin
      miscompares++;
      $display("FAIL %s grant/payload: got grant=%b type=%b addr=%h wdata=%h, want grant=%b type=%b addr=%h wdata=%h",
               tag, grant, br_type, br_address, br_write_data, exp_oh, et, ea, ew);
    end
    vectors++;
    if ({arb_busy, br_request} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s grant-cycle busy/request: got busy=%b request=%b, want busy=1 request=0", tag, arb_busy, br_request);
    end
    if (!hold) req = reqv & ~exp_oh;
    for (int i = 0; i < busy_cyc; i++) begin
      step();
      vectors++;
      if ({br_request, grant} !== {1'b0, {N{1'b0}}}) begin
        miscompares++;
        $display("FAIL %s busy stall %0d: got request=%b grant=%b, want request=0 grant=0", tag, i, br_request, grant);
      end
    end
    br_busy = 1'b0;
    step();
    vectors++;
    if ({br_request, grant} !== {1'b1, {N{1'b0}}}) begin
      miscompares++;
      $display("FAIL %s request pulse: got request=%b grant=%b, want request=1 grant=0", tag, br_request, grant);
    end
    nw           = timeout ? TO : lat;
    br_read_data = ret;
    for (int i = 0; i < nw; i++) begin
      step();
      vectors++;
      if ({br_request, done, arb_busy} !== {1'b0, {N{1'b0}}, 1'b1}) begin
        miscompares++;
        $display("FAIL %s wait %0d: got request=%b done=%b busy=%b, want request=0 done=0 busy=1",
                 tag, i, br_request, done, arb_busy);
      end
    end
    if (!timeout) br_complete = 1'b1;
    step();
    br_complete = 1'b0;
    if (!timeout && et) model_rdata = ret;
    vectors++;
    if ({done, err, rdata, br_request} !== {exp_oh, timeout, model_rdata, 1'b0}) begin
      miscompares++;
      $display("FAIL %s done: got done=%b err=%b rdata=%h request=%b, want done=%b err=%b rdata=%h request=0",
               tag, done, err, rdata, br_request, exp_oh, timeout, model_rdata);
    end
    step();
    vectors++;
    if ({done, err, arb_busy} !== {{N{1'b0}}, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s after done: got done=%b err=%b busy=%b, want all 0", tag, done, err, arb_busy);
    end
    model_ptr = (w + 1) % N;
  endtask

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  function automatic logic [N*DW-1:0] rand_wdatas();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (out_bus() !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h, want 0", out_bus());
    end
    step();
    vectors++;
    if (out_bus() !== '0) begin
      miscompares++;
      $display("FAIL idle after reset: got %h, want 0", out_bus());
    end
  endtask

  task automatic test_single_read();
    logic [N*AW-1:0] a;
    int g;
    a = rand_addrs();
    a[2*AW +: AW] = 5'h0A;
    do_access("single_read", 4'b0100, 4'b0100, a, rand_wdatas(), 32'hDEADBEEF, 0, 2, 1'b0, 1'b0, g);
  endtask

  task automatic test_single_write();
    logic [N*DW-1:0] d;
    int g;
    d = rand_wdatas();
    d[0 +: DW] = 32'h12345678;
    do_access("single_write", 4'b0001, 4'b0000, rand_addrs(), d, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0, g);
  endtask

  task automatic test_fairness();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int g;
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      do_access("fairness", 4'b1111, 4'($urandom), rand_addrs(), rand_wdatas(), $urandom,
                0, n % 3, 1'b0, 1'b1, g);
      vectors++;
      if (g !== order[n]) begin
        miscompares++;
        $display("FAIL fairness order %0d: got requester %0d, want %0d", n, g, order[n]);
      end
    end
    req = '0;
  endtask

  task automatic test_busy();
    int g;
    do_access("busy_stall", 4'b1000, 4'b1000, rand_addrs(), rand_wdatas(), $urandom, 5, 1, 1'b0, 1'b0, g);
  endtask

  task automatic test_timeout();
    int g;
    do_access("timeout", 4'b0010, 4'b0010, rand_addrs(), rand_wdatas(), $urandom, 0, 0, 1'b1, 1'b0, g);
    br_read_data = $urandom;
    br_complete  = 1'b1;
    step();
    br_complete = 1'b0;
    vectors++;
    if ({grant, done, err, arb_busy, rdata} !== {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, model_rdata}) begin
      miscompares++;
      $display("FAIL late complete: got grant=%b done=%b err=%b busy=%b rdata=%h, want idle rdata=%h",
               grant, done, err, arb_busy, rdata, model_rdata);
    end
    do_access("after_timeout", 4'b1111, 4'b1111, rand_addrs(), rand_wdatas(), $urandom, 0, 1, 1'b0, 1'b0, g);
    vectors++;
    if (g !== 2) begin
      miscompares++;
      $display("FAIL after_timeout requester: got %0d, want 2", g);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    int g;
    do_access("pre_reset", 4'b0100, 4'b0000, rand_addrs(), rand_wdatas(), $urandom, 0, 0, 1'b0, 1'b0, g);
    req      = 4'b1111;
    req_type = 4'b1111;
    step();
    vectors++;
    if (grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL in-flight grant: got %b, want 1000", grant);
    end
    req = '0;
    step();
    vectors++;
    if (br_request !== 1'b1) begin
      miscompares++;
      $display("FAIL in-flight request: got %b, want 1", br_request);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_ptr   = 0;
    model_rdata = '0;
    vectors++;
    if (out_bus() !== '0) begin
      miscompares++;
      $display("FAIL async reset outputs: got %h, want 0", out_bus());
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_bus() !== '0) begin
        miscompares++;
        $display("FAIL post-reset quiet %0d: got %h, want 0", i, out_bus());
      end
    end
    do_access("post_reset", 4'b1111, 4'($urandom), rand_addrs(), rand_wdatas(), $urandom, 0, 1, 1'b0, 1'b0, g);
    vectors++;
    if (g !== 0) begin
      miscompares++;
      $display("FAIL post_reset requester: got %0d, want 0", g);
    end
    req = '0;
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 24; n++) begin
      do_access("random", N'($urandom_range(1, 15)), 4'($urandom), rand_addrs(), rand_wdatas(), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 4), 1'b0, 1'($urandom), g);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_fairness();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m_ocp_arbiter.md
# m_ocp_arbiter

Round-robin arbiter that shares one OCP master bridge (m_ocp_slave_bridge memory-access port) between NUM_REQ local requesters. It selects one pending request and latches its command, address and write data. It issues a one-cycle request to the bridge, waits for the bridge's completion pulse, returns read data and a done pulse to the winner, and enforces a completion timeout. It sits between the requesting engines and the single bridge instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, data width (matches bridge)
- ADDR_WIDTH, 5, address width (matches bridge)
- TIMEOUT, 255, maximum cycles in WAIT before error (1..65535)
- clk  in  1  clock
- reset_n  in  1  reset; one clock, asynchronous assert, active-low
- req  in  NUM_REQ  per-requester request, level, held until grant
- req_type  in  NUM_REQ  per-requester access type, 1 = read, 0 = write
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- grant  out  NUM_REQ  one-hot, one-cycle pulse when the request is latched
- done  out  NUM_REQ  one-hot, one-cycle pulse at end of access
- rdata  out  DATA_WIDTH  read data, valid while done is high (read access)
- err  out  1  one-cycle pulse with done when the access timed out
- arb_busy  out  1  high in any state other than IDLE
- br_request  out  1  to bridge mem_access_request, one-cycle pulse
- br_type  out  1  to bridge mem_access_type
- br_address  out  ADDR_WIDTH  to bridge mem_address
- br_write_data  out  DATA_WIDTH  to bridge mem_write_data
- br_read_data  in  DATA_WIDTH  from bridge mem_read_data
- br_complete  in  1  from bridge mem_access_complete, one-cycle pulse
- br_busy  in  1  from bridge busy

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is set, select the first set bit scanning from rr_ptr upward with wrap. Then:
  - latch that requester's type, address and write data into br_* registers;
  - record its index;
  - pulse grant[index];
  - go to ISSUE.
- Requesters must hold req and payload stable until grant. Deasserting req before grant is legal; that requester is simply not selected.
- ISSUE:
  - When br_busy = 0, drive br_request = 1 for exactly one cycle, clear the timeout counter and go to WAIT.
  - When br_busy = 1, hold with br_request = 0.
- WAIT:
  - br_complete = 1: capture br_read_data into rdata (reads only; on writes rdata keeps its previous value) and go to RESP.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT, set the err flag and go to RESP.
- RESP: pulse done[index] for one cycle; err = flag; set rr_ptr = (index+1) mod NUM_REQ; clear the flag; go to IDLE.
- br_complete received outside WAIT, including a late completion after a timeout, is ignored.
- Exactly one access is outstanding at a time. br_address, br_type and br_write_data hold their values from grant until the next grant.
- Reset values: state IDLE, rr_ptr 0, grant 0, done 0, err 0, br_request 0, br_type 0, br_address 0, br_write_data 0, rdata 0, arb_busy 0, counter 0.
- Reset asserted mid-access returns everything to reset values immediately. The in-flight requester receives no done.

## Timing
- The cycle after req is seen in IDLE: grant pulse and state ISSUE.
- With br_busy = 0, br_request is high in the cycle after grant.
- done is asserted 1 cycle after the br_complete cycle (RESP state).
- Minimum request-to-done latency = 3 + bridge latency. Back-to-back: a new grant is possible 1 cycle after done (IDLE cycle).
- Timeout: err/done assert TIMEOUT+1 cycles after the cycle in which br_request was high.
- Simultaneous requests: exactly one grant per arbitration. rr_ptr ensures each requester waits at most NUM_REQ-1 other accesses.
- All outputs are registered. There is no combinational path from req or br_* inputs to any output.

## Test plan
- Single read: req[2]=1, type=1, addr=5'h0A. Expect:
  - grant=4'b0100, br_address=5'h0A, br_type=1;
  - bridge returns 32'hDEADBEEF with br_complete;
  - next cycle done=4'b0100, rdata=32'hDEADBEEF, err=0.
- Single write: req[0]=1, type=0, wdata=32'h12345678. Expect br_write_data=32'h12345678, br_type=0, and after completion done[0]=1 with rdata unchanged.
- Fairness: all four req held high continuously from reset. Expect grant order 0,1,2,3,0,1 with no requester granted twice before every other one.
- br_busy held 1 for 5 cycles after grant. Expect br_request=0 during those cycles, then a single br_request pulse on the first cycle br_busy=0.
- Timeout with TIMEOUT=8 and no br_complete. Expect done and err pulsed together 9 cycles after br_request. A later br_complete is ignored, and the next requester is then granted normally.
- Reset_n pulled low in WAIT. Expect all outputs at reset values asynchronously, no done pulse, and the next arbitration starting from requester 0.
